// File: rtl/rv_thread_sched_if.sv
// Launch / issue / retire handshake bundle between a pipeline (master) and the thread scheduler (slave).
interface rv_thread_sched_if #(
  parameter int TIDW = 2
) ();
  logic            start_valid;
  logic [TIDW-1:0] start_tid;
  logic [31:0]     start_pc;
  logic            issue_valid;
  logic [TIDW-1:0] issue_tid;
  logic [31:0]     issue_pc;
  logic            issue_ready;
  logic            ret_valid;
  logic [TIDW-1:0] ret_tid;
  logic [1:0]      ret_op;
  logic [31:0]     ret_pc;

  modport master (
    output start_valid, start_tid, start_pc, issue_ready,
    output ret_valid, ret_tid, ret_op, ret_pc,
    input  issue_valid, issue_tid, issue_pc
  );

  modport slave (
    input  start_valid, start_tid, start_pc, issue_ready,
    input  ret_valid, ret_tid, ret_op, ret_pc,
    output issue_valid, issue_tid, issue_pc
  );
endinterface

// File: rtl/rv_thread_sched.sv
// Round-robin barrel scheduler for NTHREADS hardware threads; RV_SCHED_PERF_EN adds per-thread issue counters.
// Issue offer is combinational from registered state (0 cycles); offer stays put while issue_ready is low.
module rv_thread_sched #(
  parameter int NTHREADS = 4,
  parameter int TIDW     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rv_thread_sched_if.slave      bus,
  input  logic [NTHREADS-1:0]   wake,
  output logic [2*NTHREADS-1:0] thread_state,
  output logic                  busy
`ifdef RV_SCHED_PERF_EN
  ,
  input  logic [TIDW-1:0]       perf_tid,
  output logic [31:0]           perf_count
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READY  = 2'd1,
    ISSUED = 2'd2,
    WAIT   = 2'd3
  } thr_state_e;

  thr_state_e      state [NTHREADS];
  logic [31:0]     pc    [NTHREADS];
  logic [TIDW-1:0] rr_ptr;

  logic            sel_found;
  logic [TIDW-1:0] sel_tid;
  logic [TIDW-1:0] cand;
  logic            accept;

  // Search starts just past the last accepted thread; the final step wraps back onto rr_ptr itself.
  always_comb begin
    sel_found = 1'b0;
    sel_tid   = '0;
    cand      = '0;
    for (int k = 1; k <= NTHREADS; k++) begin
      cand = rr_ptr + TIDW'(k);
      if (!sel_found && state[cand] == READY) begin
        sel_found = 1'b1;
        sel_tid   = cand;
      end
    end
  end

  assign accept          = sel_found && bus.issue_ready;
  assign bus.issue_valid = sel_found;
  assign bus.issue_tid   = sel_found ? sel_tid : '0;
  assign bus.issue_pc    = sel_found ? pc[sel_tid] : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTHREADS; i++) begin
        state[i] <= IDLE;
        pc[i]    <= 32'd0;
      end
      rr_ptr <= TIDW'(NTHREADS - 1);
    end else begin
      if (accept) begin
        rr_ptr <= sel_tid;
      end
      for (int i = 0; i < NTHREADS; i++) begin
        case (state[i])
          IDLE: begin
            if (bus.start_valid && bus.start_tid == TIDW'(i)) begin
              state[i] <= READY;
              pc[i]    <= bus.start_pc;
            end
          end
          READY: begin
            if (accept && sel_tid == TIDW'(i)) begin
              state[i] <= ISSUED;
            end
          end
          ISSUED: begin
            if (bus.ret_valid && bus.ret_tid == TIDW'(i)) begin
              pc[i] <= bus.ret_pc;
              case (bus.ret_op)
                // A wake landing with the block retire must not be lost.
                2'd1:    state[i] <= wake[i] ? READY : WAIT;
                2'd2:    state[i] <= IDLE;
                default: state[i] <= READY;
              endcase
            end
          end
          WAIT: begin
            if (wake[i]) begin
              state[i] <= READY;
            end
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    thread_state = '0;
    for (int i = 0; i < NTHREADS; i++) begin
      thread_state[2*i +: 2] = state[i];
    end
  end

  assign busy = |thread_state;

`ifdef RV_SCHED_PERF_EN
  logic [31:0] issue_cnt [NTHREADS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTHREADS; i++) begin
        issue_cnt[i] <= 32'd0;
      end
    end else if (accept) begin
      issue_cnt[sel_tid] <= issue_cnt[sel_tid] + 32'd1;
    end
  end

  assign perf_count = issue_cnt[perf_tid];
`endif

endmodule

// File: tb/tb_rv_thread_sched.sv
// Bench for rv_thread_sched: a thread-level model checked every cycle plus directed scenarios with literal expectations.
module tb_rv_thread_sched;
  localparam int N = 4;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   wake;
  logic [2*N-1:0] thread_state;
  logic           busy;
`ifdef RV_SCHED_PERF_EN
  logic [1:0]     perf_tid;
  logic [31:0]    perf_count;
`endif

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  int          rec_tid [$];
  logic [31:0] rec_pc  [$];

  rv_thread_sched_if #(.TIDW(2)) bus ();

  rv_thread_sched #(.NTHREADS(N), .TIDW(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .wake         (wake),
    .thread_state (thread_state),
    .busy         (busy)
`ifdef RV_SCHED_PERF_EN
    ,
    .perf_tid     (perf_tid),
    .perf_count   (perf_count)
`endif
  );

  always #5 clk = ~clk;

  // Model: thread states 0=idle 1=ready 2=issued 3=wait, PCs, last accepted thread, issue counts.
  int          m_st   [N];
  logic [31:0] m_pc   [N];
  int          m_last;
  logic [31:0] m_cnt  [N];

  function automatic int m_pick();
    for (int k = 1; k <= N; k++) begin
      if (m_st[(m_last + k) % N] == 1) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int          w;
    int          nst [N];
    logic [31:0] npc [N];
    int          rt;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int t = 0; t < N; t++) begin
          m_st[t]  = 0;
          m_pc[t]  = 32'd0;
          m_cnt[t] = 32'd0;
        end
        m_last = N - 1;
      end else begin
        w   = m_pick();
        nst = m_st;
        npc = m_pc;
        if (bus.start_valid && m_st[bus.start_tid] == 0) begin
          nst[bus.start_tid] = 1;
          npc[bus.start_tid] = bus.start_pc;
        end
        if (w >= 0 && bus.issue_ready) begin
          nst[w]   = 2;
          m_last   = w;
          m_cnt[w] = m_cnt[w] + 32'd1;
        end
        rt = int'(bus.ret_tid);
        if (bus.ret_valid && m_st[rt] == 2) begin
          npc[rt] = bus.ret_pc;
          if (bus.ret_op == 2'd2)      nst[rt] = 0;
          else if (bus.ret_op == 2'd1) nst[rt] = wake[rt] ? 1 : 3;
          else                         nst[rt] = 1;
        end
        for (int t = 0; t < N; t++) begin
          if (m_st[t] == 3 && wake[t]) nst[t] = 1;
        end
        m_st = nst;
        m_pc = npc;
      end
    end
  end

  initial begin
    int          w;
    logic [7:0]  ts;
    logic [31:0] epc;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        w   = m_pick();
        ts  = 8'd0;
        epc = 32'd0;
        for (int t = 0; t < N; t++) ts[2*t +: 2] = 2'(m_st[t]);
        if (w >= 0) epc = m_pc[w];
        chk("issue_valid", 32'(bus.issue_valid), (w >= 0) ? 32'd1 : 32'd0);
        chk("issue_tid", 32'(bus.issue_tid), (w >= 0) ? 32'(w) : 32'd0);
        chk("issue_pc", bus.issue_pc, epc);
        chk("thread_state", 32'(thread_state), 32'(ts));
        chk("busy", 32'(busy), (ts != 8'd0) ? 32'd1 : 32'd0);
`ifdef RV_SCHED_PERF_EN
        chk("perf_count", perf_count, m_cnt[perf_tid]);
`endif
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int tid, input logic [31:0] pc);
    bus.start_valid = 1'b1;
    bus.start_tid   = 2'(tid);
    bus.start_pc    = pc;
    cyc();
    bus.start_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    bus.issue_ready = 1'b0;
    bus.ret_valid   = 1'b0;
    wake            = '0;
    rst_n           = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  // Accept whatever is offered and retire it one cycle later; blk_tid's first retire blocks and is woken wake_dly cycles on.
  task automatic run(input int n, input int op_def, input int blk_tid, input logic [31:0] blk_pc, input int wake_dly);
    int          wcnt;
    bit          blocked;
    bit          acc;
    logic [1:0]  t;
    logic [31:0] p;
    wcnt    = 0;
    blocked = 1'b0;
    rec_tid.delete();
    rec_pc.delete();
    for (int i = 0; i < n; i++) begin
      acc = bus.issue_valid && bus.issue_ready;
      t   = bus.issue_tid;
      p   = bus.issue_pc;
      if (acc) begin
        rec_tid.push_back(int'(t));
        rec_pc.push_back(p);
      end
      cyc();
      wake = '0;
      if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) wake[blk_tid] = 1'b1;
      end
      bus.ret_valid = acc;
      bus.ret_tid   = t;
      if (acc && int'(t) == blk_tid && !blocked) begin
        bus.ret_op = 2'd1;
        bus.ret_pc = blk_pc;
        blocked    = 1'b1;
        wcnt       = wake_dly;
      end else begin
        bus.ret_op = 2'(op_def);
        bus.ret_pc = p + 32'd4;
      end
    end
    cyc();
    bus.ret_valid = 1'b0;
    wake          = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_tid [8];
    logic [31:0] exp_pc  [8];
    int          ones;
    exp_tid = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_pc  = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h104, 32'h204, 32'h304, 32'h404};

    bus.start_valid = 1'b0;
    bus.start_tid   = '0;
    bus.start_pc    = '0;
    bus.issue_ready = 1'b0;
    bus.ret_valid   = 1'b0;
    bus.ret_tid     = '0;
    bus.ret_op      = '0;
    bus.ret_pc      = '0;
    wake            = '0;
`ifdef RV_SCHED_PERF_EN
    perf_tid = 2'd0;
`endif
    #1;
    rst_n  = 1'b0;
    mon_en = 1'b1;
    repeat (2) cyc();
    chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
    chk("rst_thread_state", 32'(thread_state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Four threads round-robin, each retiring op 0 with pc+4.
    for (int t = 0; t < N; t++) start(t, 32'h100 * (t + 1));
    chk("a_all_ready", 32'(thread_state), 32'h55);
    chk("a_first_tid", 32'(bus.issue_tid), 32'd0);
    chk("a_first_pc", bus.issue_pc, 32'h100);
    bus.issue_ready = 1'b1;
    run(8, 0, -1, 32'd0, 0);
    chk("a_count", rec_tid.size(), 32'd8);
    if (rec_tid.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("a_order_tid", 32'(rec_tid[i]), 32'(exp_tid[i]));
        chk("a_order_pc", rec_pc[i], exp_pc[i]);
      end
    end

    // Thread 1 blocks with ret_pc 0x204 and is woken three cycles later.
    reset_pulse();
    for (int t = 0; t < N; t++) start(t, 32'h100 * (t + 1));
    bus.issue_ready = 1'b1;
    run(12, 0, 1, 32'h204, 3);
    chk("b_count", rec_tid.size(), 32'd12);
    if (rec_tid.size() == 12) begin
      ones = 0;
      for (int i = 2; i < 8; i++) if (rec_tid[i] == 1) ones++;
      chk("b_skip_while_wait", 32'(ones), 32'd0);
      chk("b_skip_tid", 32'(rec_tid[5]), 32'd2);
      chk("b_reissue_tid", 32'(rec_tid[8]), 32'd1);
      chk("b_reissue_pc", rec_pc[8], 32'h204);
    end

    // Block retire and wake on the same thread in the same cycle.
    reset_pulse();
    start(2, 32'h300);
    bus.issue_ready = 1'b1;
    cyc();
    bus.issue_ready = 1'b0;
    chk("c_issued", 32'(thread_state), 32'h20);
    bus.ret_valid = 1'b1;
    bus.ret_tid   = 2'd2;
    bus.ret_op    = 2'd1;
    bus.ret_pc    = 32'h308;
    wake          = 4'b0100;
    cyc();
    bus.ret_valid = 1'b0;
    wake          = '0;
    chk("c_same_cycle_wake", 32'(thread_state[5:4]), 32'd1);
    chk("c_pc", bus.issue_pc, 32'h308);
    bus.issue_ready = 1'b1;
    cyc();
    bus.issue_ready = 1'b0;
    bus.ret_valid   = 1'b1;
    bus.ret_pc      = 32'h30c;
    cyc();
    bus.ret_valid = 1'b0;
    chk("c_wait", 32'(thread_state), 32'h30);
    wake = 4'b0001;
    cyc();
    chk("c_wake_idle_ignored", 32'(thread_state), 32'h30);
    wake = 4'b0100;
    cyc();
    wake = '0;
    chk("c_woken", 32'(thread_state), 32'h10);

    // Backpressure: offer must hold for five stalled cycles.
    reset_pulse();
    start(0, 32'h100);
    start(1, 32'h200);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("d_stall_tid", 32'(bus.issue_tid), 32'd0);
      chk("d_stall_state", 32'(thread_state), 32'h05);
    end
    bus.issue_ready = 1'b1;
    cyc();
    bus.issue_ready = 1'b0;
    chk("d_accept_state", 32'(thread_state[1:0]), 32'd2);
    chk("d_next_tid", 32'(bus.issue_tid), 32'd1);
    chk("d_next_pc", bus.issue_pc, 32'h200);

    // Start to an active thread is ignored; halts drain everything.
    bus.start_valid = 1'b1;
    bus.start_tid   = 2'd3;
    bus.start_pc    = 32'h400;
    bus.ret_valid   = 1'b1;
    bus.ret_tid     = 2'd0;
    bus.ret_op      = 2'd2;
    bus.ret_pc      = 32'h180;
    cyc();
    bus.start_valid = 1'b0;
    bus.ret_valid   = 1'b0;
    chk("e_halt_state", 32'(thread_state), 32'h44);
    start(3, 32'hDEAD);
    chk("e_restart_ignored", 32'(thread_state), 32'h44);
    bus.issue_ready = 1'b1;
    run(4, 2, -1, 32'd0, 0);
    bus.issue_ready = 1'b0;
    chk("e_count", rec_tid.size(), 32'd2);
    if (rec_tid.size() == 2) begin
      chk("e_tid3", 32'(rec_tid[1]), 32'd3);
      chk("e_pc3", rec_pc[1], 32'h400);
    end
    chk("e_busy", 32'(busy), 32'd0);
    chk("e_state", 32'(thread_state), 32'd0);

    // Reset mid-flight with threads ISSUED, then a stale retire.
    for (int t = 0; t < N; t++) start(t, 32'h100 * (t + 1));
    bus.issue_ready = 1'b1;
    repeat (3) cyc();
    bus.issue_ready = 1'b0;
    chk("f_inflight", 32'(thread_state), 32'h6A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("f_rst_valid", 32'(bus.issue_valid), 32'd0);
    chk("f_rst_pc", bus.issue_pc, 32'd0);
    chk("f_rst_state", 32'(thread_state), 32'd0);
    chk("f_rst_busy", 32'(busy), 32'd0);
    cyc();
    rst_n = 1'b1;
`ifdef RV_SCHED_PERF_EN
    chk("f_perf_clear", perf_count, 32'd0);
`endif
    bus.ret_valid = 1'b1;
    bus.ret_tid   = 2'd0;
    bus.ret_op    = 2'd0;
    bus.ret_pc    = 32'h999;
    cyc();
    bus.ret_valid = 1'b0;
    chk("f_stale_ret", 32'(thread_state), 32'd0);
    start(2, 32'h700);
    chk("f_only_tid", 32'(bus.issue_tid), 32'd2);
    start(0, 32'h800);
    chk("f_rr_reset_tid", 32'(bus.issue_tid), 32'd0);
    chk("f_rr_reset_pc", bus.issue_pc, 32'h800);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
